// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types and constants for the cache-fill / write-through memory arbiter.
package mem_fill_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int MEM_LATENCY     = 4;
  localparam int BLOCK_OFFSET_W  = 4;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL_I,
    ST_FILL_D,
    ST_WRITE
  } state_e;

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BLOCK_OFFSET_W], BLOCK_OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// Cache-side request/fill signals and memory-side port bundle of the arbiter.
// master = arbiter view, slave = caches plus main memory.
interface mem_fill_arbiter_if;
  import mem_fill_pkg::*;

  logic              i_fetch;
  logic [ADDR_W-1:0] i_addr;
  logic              d_fetch;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_write_data;
  logic              i_fill_we;
  logic              d_fill_we;
  logic [IDX_W-1:0]  fill_word_idx;
  logic [DATA_W-1:0] fill_data;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_ack;
  logic              i_busy;
  logic              d_busy;

  modport master (
    input  i_fetch, i_addr, d_fetch, d_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_data_valid, mem_data_in,
    output mem_addr, mem_read_en, mem_write_en, mem_write_data,
           i_fill_we, d_fill_we, fill_word_idx, fill_data,
           i_fill_done, d_fill_done, d_wr_ack, i_busy, d_busy
  );

  modport slave (
    output i_fetch, i_addr, d_fetch, d_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_data_valid, mem_data_in,
    input  mem_addr, mem_read_en, mem_write_en, mem_write_data,
           i_fill_we, d_fill_we, fill_word_idx, fill_data,
           i_fill_done, d_fill_done, d_wr_ack, i_busy, d_busy
  );

endinterface

// File: rtl/mem_fill_arbiter_counter.sv
// Issue and receive word counters for one block fill; cleared while the arbiter idles.
// issue_done once all reads are issued, last_word while the final word is being received.
module mem_fill_counter
  import mem_fill_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             issue_en_i,
  input  logic             recv_en_i,
  output logic [IDX_W-1:0] issue_idx_o,
  output logic [IDX_W-1:0] recv_idx_o,
  output logic             issue_done_o,
  output logic             last_word_o
);

  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    if (clr_i) begin
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else begin
      if (issue_en_i) issue_cnt_d = issue_cnt_q + CNT_W'(1);
      if (recv_en_i)  recv_cnt_d  = recv_cnt_q + CNT_W'(1);
    end
  end

  assign issue_idx_o  = issue_cnt_q[IDX_W-1:0];
  assign recv_idx_o   = recv_cnt_q[IDX_W-1:0];
  assign issue_done_o = (issue_cnt_q == CNT_W'(WORDS_PER_BLOCK));
  assign last_word_o  = (recv_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I/D block fills and D write-throughs onto a pipelined main memory.
// Fill: 12 busy cycles from grant; write: 1 cycle. Requesters hold requests until done/ack.
module mem_fill_arbiter
  import mem_fill_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mem_fill_arbiter_if.master  mem_if
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic              issue_done, last_word;
  logic [IDX_W-1:0]  issue_idx, recv_idx;
  logic              filling, fill_we;
  logic              rd_en, wr_en;
  logic [ADDR_W-1:0] addr;
  logic              i_done, d_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  assign filling = (state_q == ST_FILL_I) || (state_q == ST_FILL_D);
  // Memory returns in issue order, so receive count alone tracks the word index.
  assign fill_we = filling && mem_if.mem_data_valid;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    addr    = '0;
    i_done  = 1'b0;
    d_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_if.d_wr_req) begin
          state_d = ST_WRITE;
        end else if (mem_if.d_fetch) begin
          state_d = ST_FILL_D;
          base_d  = block_base(mem_if.d_addr);
        end else if (mem_if.i_fetch) begin
          state_d = ST_FILL_I;
          base_d  = block_base(mem_if.i_addr);
        end
      end
      ST_FILL_I, ST_FILL_D: begin
        if (!issue_done) begin
          rd_en = 1'b1;
          addr  = base_q + ADDR_W'({issue_idx, 1'b0});
        end
        if (fill_we && last_word) begin
          state_d = ST_IDLE;
          i_done  = (state_q == ST_FILL_I);
          d_done  = (state_q == ST_FILL_D);
        end
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        addr    = mem_if.d_wr_addr;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mem_fill_counter u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (state_q == ST_IDLE),
    .issue_en_i   (rd_en),
    .recv_en_i    (fill_we),
    .issue_idx_o  (issue_idx),
    .recv_idx_o   (recv_idx),
    .issue_done_o (issue_done),
    .last_word_o  (last_word)
  );

  assign mem_if.mem_addr       = addr;
  assign mem_if.mem_read_en    = rd_en;
  assign mem_if.mem_write_en   = wr_en;
  assign mem_if.mem_write_data = wr_en ? mem_if.d_wr_data : '0;
  assign mem_if.d_wr_ack       = wr_en;
  assign mem_if.i_fill_we      = fill_we && (state_q == ST_FILL_I);
  assign mem_if.d_fill_we      = fill_we && (state_q == ST_FILL_D);
  assign mem_if.fill_word_idx  = fill_we ? recv_idx : '0;
  assign mem_if.fill_data      = fill_we ? mem_if.mem_data_in : '0;
  assign mem_if.i_fill_done    = i_done;
  assign mem_if.d_fill_done    = d_done;
  assign mem_if.i_busy         = (state_q == ST_FILL_I);
  assign mem_if.d_busy         = (state_q == ST_FILL_D) || (state_q == ST_WRITE);

endmodule
